jpeg_sram_sp: RTL and testbench

Parametrised single-port SRAM behavioural model for the JPEG decoder's line and coefficient buffers. It generalises the fixed 16384x112 store with configurable depth and width, per-lane write masking, selectable 1- or 2-cycle read latency, and a read-valid strobe. It also adds a post-reset memory-clear sequencer that gates access until the array is zeroed. Optional per-lane parity is compiled in by macro.

---
 rtl/jpeg_sram_sp.sv | 98 +++++++++
 tb/tb_jpeg_sram_sp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/jpeg_sram_sp.sv
// jpeg_sram_sp: single-port SRAM with lane masks, post-reset clear and RD_LAT 1/2; SRAM_PARITY_EN adds per-lane even parity
module jpeg_sram_sp #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 112,
  parameter int LANE_W = 8,
  parameter int RD_LAT = 1,
  localparam int LANES = DATA_W / LANE_W
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              CSN,
  input  logic              WEN,
  input  logic [LANES-1:0]  BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              iParInj,
  output logic [DATA_W-1:0] Q,
  output logic              oRdValid,
  output logic              oReady,
  output logic              oParErr
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, ai;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data, d1_q, s_d;
  logic in_rng, clr, wr, rd, rd_err, v1_q, e1_q, s_v, s_e;

  assign ai = A[IW-1:0];
  assign in_rng = {1'b0, A} < (ADDR_W+1)'(DEPTH);
  assign clr = !iReset && state_q == CLEAR;
  assign wr = !iReset && state_q == READY && !CSN && !WEN && in_rng;
  assign rd = state_q == READY && !CSN && WEN;
  assign oReady = state_q == READY;
  assign rd_data = in_rng ? mem[ai] : '0;

  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == IW'(DEPTH - 1)) ? READY : state_q;
    cnt_d = state_q == CLEAR ? cnt_q + IW'(1) : cnt_q;
  end

  always_ff @(posedge iClk)
    if (iReset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end

  always_ff @(posedge iClk)
    if (clr) mem[cnt_q] <= '0;
    else if (wr)
      for (int i = 0; i < LANES; i++)
        if (!BWEN[i]) mem[ai][i*LANE_W +: LANE_W] <= D[i*LANE_W +: LANE_W];

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par [DEPTH];
  always_ff @(posedge iClk)
    if (clr) par[cnt_q] <= '0;
    else if (wr)
      for (int i = 0; i < LANES; i++)
        if (!BWEN[i]) par[ai][i] <= ^D[i*LANE_W +: LANE_W] ^ iParInj;
  always_comb begin
    rd_err = 1'b0;
    for (int i = 0; i < LANES; i++)
      rd_err |= in_rng && ((^rd_data[i*LANE_W +: LANE_W]) != par[ai][i]);
  end
`else
  logic unused_par;
  assign unused_par = iParInj;
  assign rd_err = 1'b0;
`endif

  // RD_LAT=2 inserts one register between the array and Q
  assign s_v = RD_LAT == 2 ? v1_q : rd;
  assign s_d = RD_LAT == 2 ? d1_q : rd_data;
  assign s_e = RD_LAT == 2 ? e1_q : rd_err;

  always_ff @(posedge iClk)
    if (iReset) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
      Q <= '0;
      oRdValid <= 1'b0;
      oParErr <= 1'b0;
    end else begin
      v1_q <= rd;
      e1_q <= rd_err;
      d1_q <= rd_data;
      if (s_v) Q <= s_d;
      oRdValid <= s_v;
      oParErr <= s_v && s_e;
    end
endmodule

// File: tb/tb_jpeg_sram_sp.sv
// tb_jpeg_sram_sp: RD_LAT=1 and RD_LAT=2 instances on shared stimulus against an array-based reference model
module tb_jpeg_sram_sp;
  localparam int AW = 6, DEPTH = 32, DW = 32, LW = 8, LN = DW / LW;
  logic clk = 1'b0;
  logic rst, csn, wen, inj;
  logic [LN-1:0] bwen;
  logic [AW-1:0] a;
  logic [DW-1:0] d, q1, q2;
  logic v1, v2, r1, r2, p1, p2;
  int errors = 0, checks = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [LN-1:0] par_m [DEPTH];
  logic rdy_m = 1'b0;
  int clr_left = DEPTH;
  logic pv = 1'b0, pe = 1'b0;
  logic [DW-1:0] pd = '0, eq1 = '0, eq2 = '0;
  logic [DW-1:0] dat1, dat2, dat3;

  always #5 clk = ~clk;

  jpeg_sram_sp #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .LANE_W(LW), .RD_LAT(1)) u_lat1 (
    .iClk(clk), .iReset(rst), .CSN(csn), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
    .iParInj(inj), .Q(q1), .oRdValid(v1), .oReady(r1), .oParErr(p1));

  jpeg_sram_sp #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .LANE_W(LW), .RD_LAT(2)) u_lat2 (
    .iClk(clk), .iReset(rst), .CSN(csn), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
    .iParInj(inj), .Q(q2), .oRdValid(v2), .oReady(r2), .oParErr(p2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, c, w, input logic [LN-1:0] be, input logic [AW-1:0] ad,
                      input logic [DW-1:0] dat, input logic pi);
    logic cv, ce, ev2, ee2;
    logic [DW-1:0] cd;
    int idx;
    rst = r; csn = c; wen = w; bwen = be; a = ad; d = dat; inj = pi;
    @(posedge clk);
    idx = int'(ad);
    cv = 1'b0; ce = 1'b0; cd = '0;
    ev2 = !r && pv;
    ee2 = ev2 && pe;
    if (ev2) eq2 = pd;
    if (r) begin
      rdy_m = 1'b0; clr_left = DEPTH; eq1 = '0; eq2 = '0;
    end else if (!rdy_m) begin
      clr_left--;
      if (clr_left == 0) begin
        rdy_m = 1'b1;
        foreach (mem_m[k]) begin mem_m[k] = '0; par_m[k] = '0; end
      end
    end else if (!c && !w) begin
      if (idx < DEPTH)
        for (int i = 0; i < LN; i++)
          if (!be[i]) begin
            mem_m[idx][i*LW +: LW] = dat[i*LW +: LW];
            par_m[idx][i] = ^dat[i*LW +: LW] ^ pi;
          end
    end else if (!c) begin
      cv = 1'b1;
      if (idx < DEPTH) begin
        cd = mem_m[idx];
`ifdef SRAM_PARITY_EN
        for (int i = 0; i < LN; i++) ce |= (^cd[i*LW +: LW]) != par_m[idx][i];
`endif
      end
    end
    if (cv) eq1 = cd;
    #1;
    chk("ready1", r1, rdy_m);
    chk("ready2", r2, rdy_m);
    chk("valid1", v1, cv);
    chk("valid2", v2, ev2);
    chk("q1", q1, eq1);
    chk("q2", q2, eq2);
    if (cv) chk("perr1", p1, ce);
    if (ev2) chk("perr2", p2, ee2);
    pv = cv; pd = cd; pe = ce;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'($urandom), LN'($urandom), AW'($urandom), $urandom, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dat, input logic [LN-1:0] be, input logic pi);
    step(1'b0, 1'b0, 1'b0, be, ad, dat, pi);
  endtask

  task automatic rd(input logic [AW-1:0] ad);
    step(1'b0, 1'b0, 1'b1, LN'($urandom), ad, $urandom, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, '0, 6'd5, '1, 1'b0);
  endtask

  initial begin
    do_reset(2);
    chk("reset_q", q2, '0);
    repeat (DEPTH - 1) step(1'b0, 1'b0, 1'b0, '0, 6'd5, '1, 1'b0);
    chk("ready_early", r1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 6'd5, '1, 1'b0);
    chk("ready_rise", r2, 1'b1);
    rd(5);
    chk("clr_q", q1, '0);
    idle(1);
    wr(20, '1, '0, 1'b0);
    wr(20, '0, ~LN'(1), 1'b0);
    rd(20);
    chk("lane_q1", q1, 32'hFFFF_FF00);
    idle(1);
    chk("lane_q2", q2, 32'hFFFF_FF00);
    dat1 = $urandom; dat2 = $urandom; dat3 = $urandom;
    wr(1, dat1, '0, 1'b0);
    wr(2, dat2, '0, 1'b0);
    wr(3, dat3, '0, 1'b0);
    rd(1);
    rd(2);
    chk("b2b_q2", q2, dat1);
    rd(3);
    idle(2);
    chk("b2b_last", q2, dat3);
    wr(DEPTH - 1, 32'hA5A5_5A5A, '0, 1'b0);
    rd(DEPTH - 1);
    wr(DEPTH, '1, '0, 1'b0);
    rd(DEPTH);
    chk("oor_q", q1, '0);
    chk("oor_v", v1, 1'b1);
    idle(1);
    wr(7, 32'h1234_5678, ~LN'(8), 1'b1);
    rd(7);
`ifdef SRAM_PARITY_EN
    chk("inj_err", p1, 1'b1);
`else
    chk("inj_err", p1, 1'b0);
`endif
    wr(7, 32'h1234_5678, ~LN'(8), 1'b0);
    rd(7);
    chk("clean_err", p1, 1'b0);
    idle(1);
    repeat (400) begin
      case ($urandom_range(0, 3))
        0: idle(1);
        1: wr(AW'($urandom_range(0, DEPTH + 3)), $urandom, LN'($urandom), $urandom_range(0, 7) == 0);
        default: rd(AW'($urandom_range(0, DEPTH + 3)));
      endcase
    end
    rd(1);
    rd(2);
    rd(3);
    do_reset(1);
    idle(3);
    chk("flush_q", q2, '0);
    idle(10);
    do_reset(1);
    repeat (DEPTH - 1) idle(1);
    chk("restart_early", r2, 1'b0);
    idle(1);
    rd(1);
    rd(20);
    idle(2);
    chk("recleared", q2, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
